// File: rtl/uart_rx_if.sv
// Bus port of the UART receiver: chip-select/read-strobe access, read data
// and the interrupt line. The CPU/memory_io side uses master, the receiver slave.
interface uart_rx_if;
    logic       cs_n;
    logic       rd_n;
    logic       addr;
    logic [7:0] rd_data;
    logic       irq;

    modport master (
        output cs_n,
        output rd_n,
        output addr,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  cs_n,
        input  rd_n,
        input  addr,
        output rd_data,
        output irq
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a small receive FIFO and a polled/interrupt bus port.
// Bus handshake: an access is the active-low cs_n/rd_n strobe pair; it starts on
// the first clock where both are low after a clock where they were not, and a
// held strobe counts as a single access. rd_data is loaded at the access-start
// edge and holds until the next access start. There is no ready/wait: every
// access completes in one clock.
module uart_rx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    uart_rx_if.slave   bus,
    output logic [2:0] state_dbg
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]   DIV_FULL = 16'(CLK_DIV);
    localparam logic [15:0]   DIV_HALF = 16'(CLK_DIV / 2);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shreg, sh_next;
    logic        push, ferr_set;
    logic        rx_meta, rxs;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0] count, count_next;
    logic        overrun, ferr;
    logic        acc, acc_q, acc_start, pop, push_ok, ovr_set, stat_rd;
    logic        empty, full, busy, expire;
    logic [7:0]  status, rd_q;
    logic        irq_q;

    assign expire    = (cnt == 16'd1);
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign busy      = (state != IDLE);
    assign acc       = ~bus.cs_n & ~bus.rd_n;
    assign acc_start = acc & ~acc_q;
    assign pop       = acc_start & ~bus.addr & ~empty;
    assign stat_rd   = acc_start & bus.addr;
    // A full FIFO still accepts the byte when a pop frees a slot in the same edge.
    assign push_ok   = push & (~full | pop);
    assign ovr_set   = push & full & ~pop;
    assign status    = {3'b000, busy, full, ferr, overrun, ~empty};
    assign state_dbg = state;
    assign bus.rd_data = rd_q;
    assign bus.irq     = irq_q;

    // Two-flop synchroniser for the asynchronous serial line, idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= sh_next;
        end
    end

    // Frame sequencing: half a bit to the start-bit centre, then one bit per sample.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        sh_next    = shreg;
        push       = 1'b0;
        ferr_set   = 1'b0;
        if (state != IDLE && state != WAIT_IDLE && !expire) begin
            cnt_next = cnt - 16'd1;
        end
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_next   = DIV_HALF;
                end
            end
            START: begin
                if (expire) begin
                    if (!rxs) begin
                        state_next = DATA;
                        cnt_next   = DIV_FULL;
                        bit_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    sh_next  = {rxs, shreg[7:1]};
                    cnt_next = DIV_FULL;
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    if (rxs) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Occupancy after this edge: pop is applied before push.
    always_comb begin
        count_next = count;
        if (pop) begin
            count_next = count_next - ONE_CNT;
        end
        if (push_ok) begin
            count_next = count_next + ONE_CNT;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= shreg;
        end
    end

    // FIFO pointers, occupancy and sticky error flags (a new error beats a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            count <= count_next;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (stat_rd) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (stat_rd) begin
                ferr <= 1'b0;
            end
        end
    end

    // Bus side: access-start detection, registered read data and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 1'b0;
            rd_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            acc_q <= acc;
            irq_q <= (count_next != '0);
            if (acc_start) begin
                if (bus.addr) begin
                    rd_q <= status;
                end else if (!empty) begin
                    rd_q <= mem[head];
                end else begin
                    rd_q <= 8'h00;
                end
            end
        end
    end
endmodule
